// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Which requester owns the current access.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

    // Memory command encoding on m_rw.
    localparam logic M_READ  = 1'b0;
    localparam logic M_WRITE = 1'b1;

    // Latency counter width covers RD_LAT up to 4.
    localparam int CNT_W    = 3;
    // Streak counter width covers MAX_STREAK up to 7.
    localparam int STREAK_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data, with a saturating count of
// consecutive data wins over a waiting fetch so fetch cannot starve.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic take,    // high on every cycle the arbiter is idle and samples requests
    output logic gnt      // gnt_e value; meaningful only when a request is present
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // Data wins a tie until it has beaten a waiting fetch MAX_STREAK times in a row.
    always_comb begin
        gnt = GNT_IF;
        if (d_req && !(if_req && (streak_q == MAX_S))) begin
            gnt = GNT_D;
        end
    end

    // Streak only moves on idle cycles: cleared when fetch is absent or wins,
    // bumped (saturating) when data wins while fetch is waiting.
    always_comb begin
        streak_d = streak_q;
        if (take) begin
            if (!if_req) begin
                streak_d = '0;
            end else if (gnt == GNT_D) begin
                if (streak_q != MAX_S) begin
                    streak_d = streak_q + 1'b1;
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    // Streak register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between instruction fetch and load/store.
// Each access runs IDLE -> ACCESS -> RESP; all outputs come from flops.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int MAX_STREAK = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_rw,
    output logic [DATA_W-1:0] m_data,
    input  logic [DATA_W-1:0] m_q
);

    // Handshake: a requester raises req with stable address/data and holds it
    // until its ack pulse; ack is high for exactly the RESP cycle, with rdata
    // valid in that same cycle for reads. Requests are only sampled in IDLE,
    // so a req still high after RESP is taken as a fresh request.

    localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              m_rw_q, m_rw_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;

    logic pick_gnt;
    logic take;

    assign take = (state_q == IDLE);

    mem_arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .clock (clock),
        .reset (reset),
        .if_req(if_req),
        .d_req (d_req),
        .take  (take),
        .gnt   (pick_gnt)
    );

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        m_addr_d   = m_addr_q;
        m_rw_d     = M_READ;        // a write strobe lasts only the first ACCESS cycle
        m_data_d   = m_data_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = ACCESS;
                    gnt_d   = gnt_e'(pick_gnt);
                    if (pick_gnt == GNT_D) begin
                        m_addr_d = d_addr;
                        wr_d     = d_we;
                        if (d_we) begin
                            m_rw_d   = M_WRITE;
                            m_data_d = d_wdata;
                            cnt_d    = '0;
                        end else begin
                            cnt_d    = RD_LAT_C;
                        end
                    end else begin
                        m_addr_d = if_addr;
                        wr_d     = 1'b0;
                        cnt_d    = RD_LAT_C;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (gnt_q == GNT_D) begin
                        d_ack_d = 1'b1;
                        if (!wr_q) begin
                            d_rdata_d = m_q;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any access without an ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            m_addr_q   <= '0;
            m_rw_q     <= M_READ;
            m_data_q   <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            m_addr_q   <= m_addr_d;
            m_rw_q     <= m_rw_d;
            m_data_q   <= m_data_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign if_ack   = if_ack_q;
    assign if_rdata = if_rdata_q;
    assign d_ack    = d_ack_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = busy_q;
    assign m_addr   = m_addr_q;
    assign m_rw     = m_rw_q;
    assign m_data   = m_data_q;

endmodule
